// File: rtl/lat_mem_model_if.sv
// lat_mem_model_if: request/response handshake bundle for lat_mem_model.
// master drives requests and consumes responses; slave is the memory model.
interface lat_mem_model_if #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 1
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic [ID_W-1:0]   req_id;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [LINE_W-1:0] rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_wr;

  modport master (
    output req_valid, req_wr, req_addr,
    output req_wdata, req_id, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_id, rsp_wr
  );

  modport slave (
    input  req_valid, req_wr, req_addr,
    input  req_wdata, req_id, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_id, rsp_wr
  );
endinterface

// File: rtl/lat_mem_model.sv
// lat_mem_model: fixed-latency line memory, credit-limited pipe + response FIFO.
// Macro LAT_MEM_MODEL_WRITE_ACK_EN makes accepted writes return an ack response.
module lat_mem_model #(
  parameter int LINE_W     = 128,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 5,
  parameter int ID_W       = 1,
  parameter int QDEPTH     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic busy,
  lat_mem_model_if.slave bus
);
  localparam int OFS = $clog2(LINE_W / 8);
  localparam int NL  = 1 << DEPTH_LOG2;
  localparam int NW  = LINE_W / 32;
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CW-1:0] QMAX  = CW'(QDEPTH);
  localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);

  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  wr_acc;
  logic                  rsp_gen;
  logic                  push;
  logic                  pop;
  logic [LINE_W-1:0]     rd_line;
  logic [LINE_W-1:0]     lines [NL];

  logic [CW-1:0]         out_q, out_d;

  logic                  pv_q  [LATENCY];
  logic                  pwr_q [LATENCY];
  logic [ID_W-1:0]       pid_q [LATENCY];
  logic [LINE_W-1:0]     pd_q  [LATENCY];

  logic                  fwr_q [QDEPTH];
  logic [ID_W-1:0]       fid_q [QDEPTH];
  logic [LINE_W-1:0]     fd_q  [QDEPTH];
  logic [PW-1:0]         wp_q, rp_q;
  logic [CW-1:0]         fc_q;

  assign idx     = bus.req_addr[OFS+DEPTH_LOG2-1:OFS];
  assign bus.req_ready = en && (out_q < QMAX);
  assign accept  = bus.req_valid && bus.req_ready;
  assign wr_acc  = accept && bus.req_wr;
  assign push    = en && pv_q[LATENCY-1];
  assign pop     = bus.rsp_valid && bus.rsp_ready && en;

`ifdef LAT_MEM_MODEL_WRITE_ACK_EN
  assign rsp_gen    = accept;
  assign bus.rsp_wr = bus.rsp_valid && fwr_q[rp_q];
`else
  assign rsp_gen    = accept && !bus.req_wr;
  assign bus.rsp_wr = 1'b0;
`endif

  // Lines power up with a per-index pattern and survive reset.
  for (genvar k = 0; k < NL; k++) begin : g_line
    logic [LINE_W-1:0] line_q = {NW{32'hDEADBEEF ^ 32'(k)}};
    always_ff @(posedge clk) begin
      if (wr_acc && idx == DEPTH_LOG2'(k)) begin
        line_q <= bus.req_wdata;
      end
    end
    assign lines[k] = line_q;
  end

  assign rd_line = lines[idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pv_q[i] <= 1'b0;
      end
    end else if (en) begin
      pv_q[0]  <= rsp_gen;
      pwr_q[0] <= bus.req_wr;
      pid_q[0] <= bus.req_id;
      pd_q[0]  <= rd_line;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pwr_q[i] <= pwr_q[i-1];
        pid_q[i] <= pid_q[i-1];
        pd_q[i]  <= pd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      fc_q <= '0;
    end else begin
      if (push) begin
        fwr_q[wp_q] <= pwr_q[LATENCY-1];
        fid_q[wp_q] <= pid_q[LATENCY-1];
        fd_q[wp_q]  <= pd_q[LATENCY-1];
        wp_q        <= (wp_q == PLAST) ? '0 : wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= (rp_q == PLAST) ? '0 : rp_q + 1'b1;
      end
      fc_q <= fc_q + CW'(push) - CW'(pop);
    end
  end

  // Credits cover pipe plus FIFO, so a push can never meet a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      assert (fc_q != QMAX);
    end
  end

  assign out_d = out_q + CW'(rsp_gen) - CW'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign busy          = (out_q != '0);
  assign bus.rsp_valid = (fc_q != '0);
  assign bus.rsp_id    = bus.rsp_valid ? fid_q[rp_q] : '0;
  assign bus.rsp_data  = (bus.rsp_valid && !fwr_q[rp_q])
                       ? fd_q[rp_q] : '0;
endmodule

// File: doc/lat_mem_model.md
Name: lat_mem_model

Overview:
- Parametrised downstream memory model for L1 complex / arbiter benches.
- Stores and returns real data, unlike a garbage-pattern generator.
- Accepts one line request per cycle over a valid/ready handshake and returns responses after a fixed LATENCY, tagged with the issuing client ID.
- Credit-limited outstanding count plus a response FIFO give full back-pressure in both directions; `en` freezes the whole block.

Parameters:
- LINE_W, 128: cacheline width in bits; multiple of 32, ≥32.
- ADDR_W, 32: byte address width.
- DEPTH_LOG2, 10: log2 of the number of stored lines.
- LATENCY, 5: cycles from accept to response eligibility; ≥1.
- ID_W, 1: client ID width.
- QDEPTH, 4: maximum outstanding requests (pipe + response FIFO); ≥1.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- en, in, 1: global advance enable; 0 freezes all state.
- req_valid, in, 1: request present.
- req_ready, out, 1: request can be accepted this cycle.
- req_wr, in, 1: 1 = write line, 0 = read line.
- req_addr, in, ADDR_W: byte address; offset bits ignored.
- req_wdata, in, LINE_W: write data.
- req_id, in, ID_W: issuing client.
- rsp_valid, out, 1: response FIFO head valid.
- rsp_ready, in, 1: consumer takes response.
- rsp_data, out, LINE_W: read data (0 for write acks).
- rsp_id, out, ID_W: client ID of the response.
- rsp_wr, out, 1: response is a write ack.
- busy, out, 1: outstanding count ≠ 0.

Behaviour:
- OFS = $clog2(LINE_W/8). Line index = req_addr[OFS+DEPTH_LOG2-1:OFS]; upper bits ignored, so addresses alias modulo 2^DEPTH_LOG2 lines.
- Array is not cleared by reset. Elaboration-time content of line k = LINE_W/32 copies of (32'hDEADBEEF ^ k).
- accept = req_valid & req_ready. req_ready = en & (outstanding < QDEPTH), driven from registers only, with no combinational path from req_valid.
- On accept of a write: array[idx] <= req_wdata at that edge.
- On accept of a read: array[idx] is sampled at that edge into pipe stage 1. A write accepted earlier is therefore always visible.
- Pipe: LATENCY stages of {valid, wr, id, data}. Advances only when en=1. The last stage pushes into the response FIFO (depth QDEPTH).
  - The FIFO is never full on push; the credit rule guarantees this. Implementations must assert this in simulation.
- Latency: a request accepted at edge t, with en held high and the FIFO empty, shows rsp_valid=1 after edge t+LATENCY.
- pop = rsp_valid & rsp_ready & en. rsp_valid = FIFO not empty, independent of en. Head outputs are stable while not popped.
- outstanding: +1 on accept of a request that generates a response, −1 on pop. Simultaneous +1/−1 leaves it unchanged. Range is 0..QDEPTH.
- Responses return in acceptance order; there is no reordering across IDs.
- en=0: no accept (req_ready=0), pipe frozen, no pop. rsp_valid/rsp_data still reflect the FIFO head.
- Reset (including mid-operation): all pipe valids, FIFO pointers and outstanding clear to 0. In-flight requests are discarded; array contents are kept. On the cycle after reset: req_ready = en, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_wr=0, busy=0.

Optional Feature:
- Macro: LAT_MEM_MODEL_WRITE_ACK_EN.
- Defined: every accepted write enters the pipe and produces a response with rsp_wr=1, rsp_data=0, rsp_id=req_id. Writes consume credit.
- Undefined: writes update the array only. They enter no pipe stage, consume no credit, and produce no response. rsp_wr is tied to 0.

Test Plan:
- Read latency, default params, en=1, rsp_ready=1: read addr 0x0000_0040 (line 4), id=1 accepted at edge 10 -> rsp_valid=1 after edge 15, rsp_data = 4 copies of 32'hDEADBEEB, rsp_id=1, busy falls after the pop at edge 16.
- Write-then-read: write 0x0000_0120 data 128'h0123...CDEF, then read the same address next cycle -> read response carries 128'h0123...CDEF. With WRITE_ACK_EN, the write ack (rsp_wr=1, data 0) arrives one cycle earlier.
- Back-pressure: rsp_ready=0, issue 6 back-to-back reads -> exactly 4 accepted and req_ready=0 thereafter. Raise rsp_ready -> 4 responses in order, then req_ready=1 again.
- Freeze: en=0 for 3 cycles while a read is in stage 2 -> response delayed by exactly 3 cycles. req_ready=0 and no pop during the freeze.
- Reset mid-flight: 3 reads outstanding, assert reset 1 cycle -> rsp_valid=0, busy=0, no stale response appears. Later reads return the previously written data.
- Alias/params: DEPTH_LOG2=4, LINE_W=64, QDEPTH=1. Write addr 0x08 then read addr 0x88 -> same line data returned. Only 1 request is ever outstanding.
